// File: rtl/net_phy_pkg.sv
// rtl/net_phy_pkg.sv - shared 64b/66b line constants and scheduler state type
package net_phy_pkg;
    localparam logic [1:0]  SYNC_DATA = 2'b10;
    localparam logic [1:0]  SYNC_CTRL = 2'b01;
    localparam logic [63:0] IDLE_BLK  = 64'h0000_0000_0000_001E;

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } sched_state_t;
endpackage

// File: rtl/net_rr_pick.sv
// rtl/net_rr_pick.sv - combinational rotate-priority picker: first request at or after ptr
module net_rr_pick #(
    parameter int NQ = 4
) (
    input  logic [NQ-1:0]         req,
    input  logic [$clog2(NQ)-1:0] ptr,
    output logic [NQ-1:0]         gnt,
    output logic [$clog2(NQ)-1:0] idx,
    output logic                  any
);
    localparam int IW = $clog2(NQ);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < NQ; k++) begin
            j = (int'(ptr) + k) % NQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/net_tx_sched.sv
// rtl/net_tx_sched.sv - frame-atomic transmit scheduler from NQ queues onto the PHY TX slot
module net_tx_sched
    import net_phy_pkg::*;
#(
    parameter int NQ        = 4,
    parameter int DWIDTH    = 64,
    parameter int CWIDTH    = 2,
    parameter int MAX_BURST = 16,
    parameter int PRIO0     = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NQ-1:0]            q_empty,
    input  logic [NQ*DWIDTH-1:0]     q_data_d,
    input  logic [NQ*CWIDTH-1:0]     q_data_c,
    input  logic [NQ-1:0]            q_last,
    output logic [NQ-1:0]            q_rd,
    input  logic                     tx_ready,
    output logic                     tx_valid,
    output logic [DWIDTH-1:0]        tx_data_d,
    output logic [CWIDTH-1:0]        tx_data_c,
    output logic [$clog2(NQ)-1:0]    grant_id,
    output logic                     busy
);
    localparam int IW = $clog2(NQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST_Q = IW'(NQ - 1);

    sched_state_t      state;
    logic [IW-1:0]     rr_ptr, rr_idx, sel, next_rr;
    logic [BW-1:0]     burst_cnt, next_cnt;
    logic [NQ-1:0]     elig, rr_gnt, sel_oh;
    logic              rr_any, sel_any, adv, pop, release_now, keep_rr;
    logic [DWIDTH-1:0] sel_d;
    logic [CWIDTH-1:0] sel_c;
    logic              sel_last;

    assign elig = ~q_empty;
    assign adv  = ~tx_valid | tx_ready;

    net_rr_pick #(.NQ(NQ)) u_pick (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // In BURST the grant owner is the only candidate; an empty owner yields an idle fill.
    always_comb begin
        sel     = rr_idx;
        sel_oh  = rr_gnt;
        sel_any = rr_any;
        if (PRIO0 != 0 && elig[0]) begin
            sel     = '0;
            sel_oh  = NQ'(1);
            sel_any = 1'b1;
        end
        if (state == BURST) begin
            sel     = grant_id;
            sel_oh  = NQ'(1) << grant_id;
            sel_any = elig[grant_id];
        end
    end

    assign pop      = adv & sel_any & ~reset;
    assign q_rd     = pop ? sel_oh : '0;
    assign sel_d    = q_data_d[int'(sel)*DWIDTH +: DWIDTH];
    assign sel_c    = q_data_c[int'(sel)*CWIDTH +: CWIDTH];
    assign sel_last = q_last[sel];

    assign next_cnt    = (state == ARB) ? BW'(1) : burst_cnt + 1'b1;
    assign release_now = sel_last | (next_cnt == BW'(MAX_BURST));
    assign keep_rr     = (PRIO0 != 0) && (sel == '0);
    assign next_rr     = (sel == LAST_Q) ? '0 : sel + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            grant_id  <= '0;
            tx_valid  <= 1'b0;
            tx_data_d <= DWIDTH'(IDLE_BLK);
            tx_data_c <= CWIDTH'(SYNC_CTRL);
        end else if (adv) begin
            tx_valid <= 1'b1;
            if (pop) begin
                tx_data_d <= sel_d;
                tx_data_c <= sel_c;
                burst_cnt <= next_cnt;
                grant_id  <= sel;
                if (release_now) begin
                    state <= ARB;
                    if (!keep_rr)
                        rr_ptr <= next_rr;
                end else begin
                    state <= BURST;
                end
            end else begin
                tx_data_d <= DWIDTH'(IDLE_BLK);
                tx_data_c <= CWIDTH'(SYNC_CTRL);
            end
        end
    end

    assign busy = (state == BURST);
endmodule

// File: tb/tb_net_tx_sched.sv
// tb/tb_net_tx_sched.sv - directed self-checking bench for net_tx_sched
module tb_net_tx_sched;
    localparam logic [63:0] IDLE = 64'h0000_0000_0000_001E;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   q_empty;
    logic [255:0] q_data_d;
    logic [7:0]   q_data_c;
    logic [3:0]   q_last;
    logic [3:0]   q_rd;
    logic         tx_ready;
    logic         tx_valid;
    logic [63:0]  tx_data_d;
    logic [1:0]   tx_data_c;
    logic [1:0]   grant_id;
    logic         busy;

    int n_checks = 0;
    int n_err    = 0;

    logic [63:0] mem_d [4][64];
    logic        mem_l [4][64];
    int          head [4] = '{0, 0, 0, 0};
    int          tail [4] = '{0, 0, 0, 0};

    net_tx_sched #(
        .NQ(4), .DWIDTH(64), .CWIDTH(2), .MAX_BURST(4), .PRIO0(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .q_empty   (q_empty),
        .q_data_d  (q_data_d),
        .q_data_c  (q_data_c),
        .q_last    (q_last),
        .q_rd      (q_rd),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data_d (tx_data_d),
        .tx_data_c (tx_data_c),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Queue model: head advances on each pop strobe, tail on each push.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (q_rd[i]) head[i] <= head[i] + 1;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            q_empty[i]           = (head[i] == tail[i]);
            q_data_d[i*64 +: 64] = mem_d[i][head[i] % 64];
            q_last[i]            = mem_l[i][head[i] % 64];
            q_data_c[i*2 +: 2]   = 2'b10;
        end
    end

    function automatic logic [63:0] blk(input int q, input int n);
        return {8'hA0 + 8'(q), 48'h0, 8'(n)};
    endfunction

    task automatic push(input int q, input int n, input logic last);
        mem_d[q][tail[q] % 64] = blk(q, n);
        mem_l[q][tail[q] % 64] = last;
        tail[q] = tail[q] + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tail[i] = head[i];
        #1;
    endtask

    initial begin
        int ord [11] = '{3, 3, 3, 3, 1, 3, 3, 3, 3, 3, 3};
        bit bz  [11] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 1, 1};
        int n3;
        int q;

        reset    = 1'b1;
        tx_ready = 1'b1;
        #2;
        chk("rst_valid", tx_valid, 0);
        chk("rst_c", tx_data_c, 2'b01);
        chk("rst_d", tx_data_d, IDLE);
        chk("rst_q_rd", q_rd, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // 1: idle line
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t1_valid", tx_valid, 1);
            chk("t1_c", tx_data_c, 2'b01);
            chk("t1_d", tx_data_d, IDLE);
            chk("t1_q_rd", q_rd, 0);
        end

        // 2: two 3-block frames on queues 1 and 2
        push(1, 0, 0); push(1, 1, 0); push(1, 2, 1);
        push(2, 0, 0); push(2, 1, 0); push(2, 2, 1);
        #1;
        for (int k = 0; k < 6; k++) begin
            q = (k < 3) ? 1 : 2;
            chk("t2_q_rd", q_rd, 64'(1) << q);
            tick();
            chk("t2_d", tx_data_d, blk(q, k % 3));
            chk("t2_c", tx_data_c, 2'b10);
            chk("t2_grant", grant_id, 64'(q));
            chk("t2_busy", busy, (k % 3 == 2) ? 0 : 1);
        end
        chk("t2_rr", dut.rr_ptr, 3);
        chk("t2_q_rd_end", q_rd, 0);

        // 3: burst limit 4 on queue 3 lets queue 1 in
        for (int n = 0; n < 10; n++) push(3, n, 0);
        push(1, 0, 1);
        #1;
        n3 = 0;
        for (int k = 0; k < 11; k++) begin
            tick();
            if (ord[k] == 3) begin
                chk("t3_d", tx_data_d, blk(3, n3));
                n3++;
            end else begin
                chk("t3_d", tx_data_d, blk(1, 0));
            end
            chk("t3_busy", busy, 64'(bz[k]));
        end
        tick();
        chk("t3_underrun_d", tx_data_d, IDLE);
        chk("t3_underrun_busy", busy, 1);
        chk("t3_underrun_grant", grant_id, 3);
        do_reset();

        // 4: queue 0 priority waits for the queue 2 frame to end
        push(2, 0, 0); push(2, 1, 0); push(2, 2, 1);
        #1;
        tick();
        chk("t4_d0", tx_data_d, blk(2, 0));
        chk("t4_grant0", grant_id, 2);
        push(0, 0, 0); push(0, 1, 1); push(1, 0, 1);
        #1;
        chk("t4_q_rd_hold", q_rd, 4'b0100);
        tick();
        chk("t4_d1", tx_data_d, blk(2, 1));
        tick();
        chk("t4_d2", tx_data_d, blk(2, 2));
        chk("t4_busy2", busy, 0);
        chk("t4_rr2", dut.rr_ptr, 3);
        chk("t4_q_rd_q0", q_rd, 4'b0001);
        tick();
        chk("t4_d3", tx_data_d, blk(0, 0));
        chk("t4_grant3", grant_id, 0);
        chk("t4_busy3", busy, 1);
        tick();
        chk("t4_d4", tx_data_d, blk(0, 1));
        chk("t4_rr4", dut.rr_ptr, 3);
        tick();
        chk("t4_d5", tx_data_d, blk(1, 0));
        chk("t4_rr5", dut.rr_ptr, 2);

        // 5: backpressure mid-burst
        push(2, 0, 0); push(2, 1, 0); push(2, 2, 1);
        #1;
        tick();
        chk("t5_d0", tx_data_d, blk(2, 0));
        chk("t5_busy0", busy, 1);
        tx_ready = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t5_stall_q_rd", q_rd, 0);
            tick();
            chk("t5_stall_d", tx_data_d, blk(2, 0));
            chk("t5_stall_valid", tx_valid, 1);
        end
        tx_ready = 1'b1;
        #1;
        chk("t5_q_rd_resume", q_rd, 4'b0100);
        tick();
        chk("t5_d1", tx_data_d, blk(2, 1));
        tick();
        chk("t5_d2", tx_data_d, blk(2, 2));
        chk("t5_rr", dut.rr_ptr, 3);

        // 6: mid-frame underrun, then reset during BURST
        push(1, 0, 0); push(1, 1, 0);
        #1;
        tick();
        chk("t6_d0", tx_data_d, blk(1, 0));
        tick();
        chk("t6_d1", tx_data_d, blk(1, 1));
        chk("t6_q_rd_empty", q_rd, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("t6_idle_d", tx_data_d, IDLE);
            chk("t6_idle_c", tx_data_c, 2'b01);
            chk("t6_idle_busy", busy, 1);
            chk("t6_idle_grant", grant_id, 1);
        end
        push(1, 2, 0);
        #1;
        chk("t6_q_rd_back", q_rd, 4'b0010);
        tick();
        chk("t6_d2", tx_data_d, blk(1, 2));
        chk("t6_busy2", busy, 1);
        push(1, 3, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", tx_valid, 0);
        chk("t6_rst_d", tx_data_d, IDLE);
        chk("t6_rst_c", tx_data_c, 2'b01);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_grant", grant_id, 0);
        chk("t6_rst_q_rd", q_rd, 0);
        chk("t6_rst_rr", dut.rr_ptr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tail[i] = head[i];
        #1;
        tick();
        chk("t6_post_valid", tx_valid, 1);
        chk("t6_post_d", tx_data_d, IDLE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
